// File: rtl/vga_cap_pkg.sv
// Shared types and default geometry for the VGA frame capture block.
// The 800/525 totals are not used by the RTL; they describe standard timing for benches.
package vga_cap_pkg;

   typedef enum logic [1:0] {
      StSeek,
      StWaitVsEnd,
      StCapture
   } cap_state_e;

   localparam int unsigned VgaHActive = 640;
   localparam int unsigned VgaVActive = 480;
   localparam int unsigned VgaHTotal  = 800;
   localparam int unsigned VgaVTotal  = 525;

   function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/vga_frame_capture_sync_edge.sv
// Registers one sync input on pix_ce, normalises it to active-high and produces
// assert/deassert edge pulses that are valid in the clk cycle after the sampling strobe.
module vga_sync_edge #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pix_ce,
   input  logic sync_raw,
   output logic rise,
   output logic fall
);

   logic cur_q, prev_q, vld_q, have_q, primed_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q    <= 1'b0;
         prev_q   <= 1'b0;
         vld_q    <= 1'b0;
         have_q   <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         vld_q <= pix_ce;
         if (pix_ce) begin
            cur_q    <= sync_raw ^ ACTIVE_LOW;
            prev_q   <= cur_q;
            have_q   <= 1'b1;
            // Edges need two real samples; avoids a false edge right after reset.
            primed_q <= have_q;
         end
      end
   end

   assign rise = vld_q & primed_q & cur_q & ~prev_q;
   assign fall = vld_q & primed_q & ~cur_q & prev_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Rebuilds (x, y, rgb) pixel writes from a VGA stream and checks line/frame geometry.
// Two-stage pipeline: pix_ce-qualified input register, then the capture/output register.
module vga_frame_capture
   import vga_cap_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = VgaHActive,
   parameter int unsigned V_ACTIVE        = VgaVActive,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter int unsigned CW              = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_ce,
   input  logic          h_sync,
   input  logic          v_sync,
   input  logic          and_enable,
   input  logic [7:0]    red_in,
   input  logic [7:0]    green_in,
   input  logic [7:0]    blue_in,
   output logic          cap_valid,
   output logic [CW-1:0] cap_x,
   output logic [CW-1:0] cap_y,
   output logic [23:0]   cap_rgb,
   output logic          frame_done,
   output logic [15:0]   frame_cnt,
   output logic          line_err,
   output logic          frame_err
);

   localparam logic [CW-1:0] CoordMax = '1;
   localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);

   logic hs_rise, hs_fall_unused, vs_rise, vs_fall;

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs (
      .clk      (clk),
      .reset    (reset),
      .pix_ce   (pix_ce),
      .sync_raw (h_sync),
      .rise     (hs_rise),
      .fall     (hs_fall_unused)
   );

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs (
      .clk      (clk),
      .reset    (reset),
      .pix_ce   (pix_ce),
      .sync_raw (v_sync),
      .rise     (vs_rise),
      .fall     (vs_fall)
   );

   logic        vld_q, en_q;
   logic [23:0] rgb_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         en_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         vld_q <= pix_ce;
         if (pix_ce) begin
            en_q  <= and_enable;
            rgb_q <= pack_rgb(red_in, green_in, blue_in);
         end
      end
   end

   cap_state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= StSeek;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSeek:      if (vs_rise) state_d = StWaitVsEnd;
         StWaitVsEnd: if (vs_fall) state_d = StCapture;
         StCapture:   if (vs_rise) state_d = StWaitVsEnd;
         default:     state_d = StSeek;
      endcase
   end

   logic [CW-1:0] x_q, x_d, y_q, y_d, px_q, px_d, cx_q, cx_d, cy_q, cy_d;
   logic [23:0]   crgb_q, crgb_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic          cval_q, cval_d, done_q, done_d, lerr_q, lerr_d, ferr_q, ferr_d;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      px_d   = px_q;
      cx_d   = cx_q;
      cy_d   = cy_q;
      crgb_d = crgb_q;
      fcnt_d = fcnt_q;
      lerr_d = lerr_q;
      ferr_d = ferr_q;
      cval_d = 1'b0;
      done_d = 1'b0;
      unique case (state_q)
         StWaitVsEnd: begin
            if (vs_fall) begin
               x_d  = '0;
               y_d  = '0;
               px_d = '0;
            end
         end
         StCapture: begin
            if (vld_q && en_q) begin
               cval_d = 1'b1;
               cx_d   = x_q;
               cy_d   = y_q;
               crgb_d = rgb_q;
               if (x_q == CoordMax) lerr_d = 1'b1;
               else                 x_d = x_q + 1'b1;
               if (px_q != CoordMax) px_d = px_q + 1'b1;
            end
            // Line close runs before the frame check so a simultaneous edge sees the final y.
            if ((hs_rise || vs_rise) && px_d != '0) begin
               if (px_d != HActive) lerr_d = 1'b1;
               if (y_q == CoordMax) ferr_d = 1'b1;
               else                 y_d = y_q + 1'b1;
               x_d  = '0;
               px_d = '0;
            end
            if (vs_rise) begin
               if (y_d != VActive) ferr_d = 1'b1;
               done_d = 1'b1;
               fcnt_d = fcnt_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         px_q   <= '0;
         cx_q   <= '0;
         cy_q   <= '0;
         crgb_q <= '0;
         fcnt_q <= '0;
         lerr_q <= 1'b0;
         ferr_q <= 1'b0;
         cval_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         px_q   <= px_d;
         cx_q   <= cx_d;
         cy_q   <= cy_d;
         crgb_q <= crgb_d;
         fcnt_q <= fcnt_d;
         lerr_q <= lerr_d;
         ferr_q <= ferr_d;
         cval_q <= cval_d;
         done_q <= done_d;
      end
   end

   assign cap_valid  = cval_q;
   assign cap_x      = cx_q;
   assign cap_y      = cy_q;
   assign cap_rgb    = crgb_q;
   assign frame_done = done_q;
   assign frame_cnt  = fcnt_q;
   assign line_err   = lerr_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 8x4 geometry (12x8 totals, active-low sync).
// A frame table drives whole frames; a monitor checks every captured pixel and its latency.
module tb_vga_frame_capture;

   localparam int H   = 8;
   localparam int HFP = 1;
   localparam int HS  = 2;
   localparam int HBP = 1;
   localparam int HT  = H + HFP + HS + HBP;
   localparam int V   = 4;
   localparam int VFP = 1;
   localparam int VS  = 2;
   localparam int VBP = 1;
   localparam int VT  = V + VFP + VS + VBP;
   localparam int CWB = 10;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            pix_ce = 1'b0;
   logic            h_sync = 1'b1;
   logic            v_sync = 1'b1;
   logic            and_enable = 1'b0;
   logic [7:0]      red_in = '0, green_in = '0, blue_in = '0;
   logic            cap_valid, frame_done, line_err, frame_err;
   logic [CWB-1:0]  cap_x, cap_y;
   logic [23:0]     cap_rgb;
   logic [15:0]     frame_cnt;

   vga_frame_capture #(
      .H_ACTIVE        (H),
      .V_ACTIVE        (V),
      .SYNC_ACTIVE_LOW (1'b1),
      .CW              (CWB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_ce     (pix_ce),
      .h_sync     (h_sync),
      .v_sync     (v_sync),
      .and_enable (and_enable),
      .red_in     (red_in),
      .green_in   (green_in),
      .blue_in    (blue_in),
      .cap_valid  (cap_valid),
      .cap_x      (cap_x),
      .cap_y      (cap_y),
      .cap_rgb    (cap_rgb),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .line_err   (line_err),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int             cyc;
      logic [CWB-1:0] x;
      logic [CWB-1:0] y;
      logic [23:0]    rgb;
   } pix_t;

   pix_t           expq[$];
   pix_t           mon_e;
   int             errors = 0;
   int             checks = 0;
   int             dones = 0;
   bit             capturing = 0;
   logic [CWB-1:0] last_x = '0, last_y = '0;
   logic [23:0]    last_rgb = '0;

   // Pixel monitor: every cap_valid must match the oldest expected pixel at its due cycle.
   always @(negedge clk) begin
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_pixel: no cap_valid at cycle %0d, required pixel (%0d,%0d)",
                  expq[0].cyc, expq[0].x, expq[0].y);
         void'(expq.pop_front());
      end
      if (cap_valid) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cap: got pixel (%0d,%0d) at cycle %0d, required none",
                     cap_x, cap_y, cyc);
         end else begin
            mon_e = expq.pop_front();
            if (mon_e.cyc != cyc || cap_x !== mon_e.x || cap_y !== mon_e.y ||
                cap_rgb !== mon_e.rgb) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d,%h)@%0d, required (%0d,%0d,%h)@%0d",
                        cap_x, cap_y, cap_rgb, cyc, mon_e.x, mon_e.y, mon_e.rgb, mon_e.cyc);
            end
         end
         last_x   = cap_x;
         last_y   = cap_y;
         last_rgb = cap_rgb;
      end
      if (frame_done) dones++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cap_valid"}, 32'(cap_valid), 0);
      chk({tag, "_cap_x"}, 32'(cap_x), 0);
      chk({tag, "_cap_y"}, 32'(cap_y), 0);
      chk({tag, "_cap_rgb"}, 32'(cap_rgb), 0);
      chk({tag, "_frame_done"}, 32'(frame_done), 0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
      chk({tag, "_line_err"}, 32'(line_err), 0);
      chk({tag, "_frame_err"}, 32'(frame_err), 0);
   endtask

   // hs/vs are active-high here; the DUT sees them inverted (active-low sync).
   task automatic drive(input bit ce, input bit hs, input bit vs, input bit en,
                        input logic [23:0] rgb, input bit rst);
      @(negedge clk);
      #1;
      reset      = rst;
      pix_ce     = ce;
      h_sync     = ~hs;
      v_sync     = ~vs;
      and_enable = en;
      {red_in, green_in, blue_in} = rgb;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 24'h0, 1);
      drive(0, 0, 0, 0, 24'h0, 1);
      drive(0, 0, 0, 0, 24'h0, 0);
      expq.delete();
      capturing = 0;
      dones = 0;
      @(negedge clk);
      chk_zero("after_reset");
   endtask

   task automatic drive_frame(input int act, input int short_l, input bit toggle,
                              input bit simul, input int rst_l);
      bit          vs, hs, en, hs_on;
      int          hs0, npx;
      logic [23:0] rgb;
      for (int l = 0; l < VT; l++) begin
         vs    = (l >= V + VFP) && (l < V + VFP + VS);
         hs_on = !(simul && l >= act - 1 && l < V + VFP);
         hs0   = (simul && l == V + VFP) ? 0 : H + HFP;
         npx   = (l < act) ? ((l == short_l) ? H - 1 : H) : 0;
         if (l == short_l) chk("line_err_before_short", 32'(line_err), 0);
         for (int j = 0; j < HT; j++) begin
            hs  = hs_on && j >= hs0 && j < hs0 + HS;
            en  = j < npx;
            rgb = {8'(j), 8'(l), 8'h5A};
            if (toggle) drive(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1, 24'hFFFFFF, 0);
            if (l == rst_l && j == 3) begin
               drive(1, hs, vs, 0, rgb, 1);
               expq.delete();
               capturing = 0;
               @(negedge clk);
               chk_zero("mid_reset");
               dones = 0;
            end
            drive(1, hs, vs, en, rgb, 0);
            if (en && capturing) expq.push_back('{cyc + 2, CWB'(j), CWB'(l), rgb});
         end
         if (l == short_l) chk("line_err_after_short", 32'(line_err), 1);
         if (l == V + VFP + VS - 1) capturing = 1;
      end
   endtask

   typedef struct {
      bit          rst_before;
      int          act;
      int          short_l;
      bit          toggle;
      bit          simul;
      int          rst_l;
      int          exp_cnt;
      int          exp_dones;
      bit          exp_lerr;
      bit          exp_ferr;
      int          exp_lx;
      int          exp_ly;
      logic [23:0] exp_rgb;
   } vec_t;

   vec_t vecs[11];

   initial begin
      //          rst act sh  tg sim rl  cnt dn le fe  lx  ly  rgb
      vecs[0]  = '{1, V,   -1, 0, 0, -1, 0, 0, 0, 0, -1, -1, 24'h0};
      vecs[1]  = '{0, V,   -1, 0, 0, -1, 1, 1, 0, 0,  7,  3, 24'h07035A};
      vecs[2]  = '{0, V,   -1, 0, 0, -1, 2, 2, 0, 0,  7,  3, 24'h07035A};
      vecs[3]  = '{0, V,   -1, 1, 0, -1, 3, 3, 0, 0,  7,  3, 24'h07035A};
      vecs[4]  = '{0, V,   -1, 0, 1, -1, 4, 4, 0, 0,  7,  3, 24'h07035A};
      vecs[5]  = '{0, V,    1, 0, 0, -1, 5, 5, 1, 0,  7,  3, 24'h07035A};
      vecs[6]  = '{1, V,   -1, 0, 0, -1, 0, 0, 0, 0, -1, -1, 24'h0};
      vecs[7]  = '{0, V-1, -1, 0, 0, -1, 1, 1, 0, 1,  7,  2, 24'h07025A};
      vecs[8]  = '{1, V,   -1, 0, 0, -1, 0, 0, 0, 0, -1, -1, 24'h0};
      vecs[9]  = '{0, V,   -1, 0, 0,  2, 0, 0, 0, 0, -1, -1, 24'h0};
      vecs[10] = '{0, V,   -1, 0, 0, -1, 1, 1, 0, 0,  7,  3, 24'h07035A};

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].rst_before) do_reset();
         drive_frame(vecs[i].act, vecs[i].short_l, vecs[i].toggle, vecs[i].simul, vecs[i].rst_l);
         @(negedge clk);
         chk($sformatf("v%0d_frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].exp_cnt));
         chk($sformatf("v%0d_frame_done_pulses", i), 32'(dones), 32'(vecs[i].exp_dones));
         chk($sformatf("v%0d_line_err", i), 32'(line_err), 32'(vecs[i].exp_lerr));
         chk($sformatf("v%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
         if (vecs[i].exp_lx >= 0) begin
            chk($sformatf("v%0d_last_x", i), 32'(last_x), 32'(vecs[i].exp_lx));
            chk($sformatf("v%0d_last_y", i), 32'(last_y), 32'(vecs[i].exp_ly));
            chk($sformatf("v%0d_last_rgb", i), 32'(last_rgb), 32'(vecs[i].exp_rgb));
         end
      end

      repeat (4) drive(0, 0, 0, 0, 24'h0, 0);
      chk("pending_pixels_drained", 32'(expq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
